// File: rtl/arbitro_rr_4_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The grant side feeds the 2-to-4 decoder inputs a0, a1 and en.
interface arbitro_rr_4_if;
    logic [3:0] sol;
    logic       liberar;
    logic       a0;
    logic       a1;
    logic       en;

    modport master (
        output sol,
        output liberar,
        input  a0,
        input  a1,
        input  en
    );

    modport slave (
        input  sol,
        input  liberar,
        output a0,
        output a1,
        output en
    );
endinterface

// File: rtl/arbitro_rr_4.sv
// Four-way round-robin arbiter with bounded tenure; the registered
// index and enable drive a 2-to-4 decoder that forms the one-hot grant.
module arbitro_rr_4 #(
    parameter int TIEMPO_MAX = 8,
    parameter int ANCHO_CNT  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    arbitro_rr_4_if.slave bus
);
    typedef enum logic [1:0] {
        REPOSO    = 2'b00,
        CONCEDIDO = 2'b01
    } estado_t;

    localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(TIEMPO_MAX - 1);

    estado_t              estado_q, estado_d;
    logic [1:0]           idx_q, idx_d;
    logic                 en_q, en_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    logic [1:0]           ptr_q, ptr_d;

    logic [1:0] pick;
    logic       hay_sol;
    logic       fin;

    // First set bit of v scanning upward from p, wrapping mod 4.
    function automatic logic [1:0] elegir(
        input logic [3:0] v,
        input logic [1:0] p
    );
        logic [1:0] k;
        logic       hit;
        elegir = p;
        hit    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k = p + 2'(i);
            if (!hit && v[k]) begin
                elegir = k;
                hit    = 1'b1;
            end
        end
    endfunction

    assign pick    = elegir(bus.sol, ptr_q);
    assign hay_sol = |bus.sol;
    assign fin     = !bus.sol[idx_q] || bus.liberar || (cnt_q == CNT_FIN);

    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        unique case (estado_q)
            REPOSO: begin
                en_d = 1'b0;
                if (hay_sol) begin
                    estado_d = CONCEDIDO;
                    idx_d    = pick;
                    en_d     = 1'b1;
                    cnt_d    = '0;
                    ptr_d    = pick + 2'd1;
                end
            end
            CONCEDIDO: begin
                if (!fin) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (hay_sol) begin
                    // Zero-bubble regrant; the old holder now has lowest priority.
                    idx_d = pick;
                    en_d  = 1'b1;
                    cnt_d = '0;
                    ptr_d = pick + 2'd1;
                end else begin
                    estado_d = REPOSO;
                    en_d     = 1'b0;
                end
            end
            default: begin
                estado_d = REPOSO;
                en_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            idx_q    <= '0;
            en_q     <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            en_q     <= en_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.a0 = idx_q[0];
    assign bus.a1 = idx_q[1];
    assign bus.en = en_q;
endmodule

// File: tb/tb_arbitro_rr_4.sv
// Directed bench for arbitro_rr_4: default tenure of 8 on one
// instance, tenure of 1 on a second instance sharing clock and reset.
module tb_arbitro_rr_4;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arbitro_rr_4_if if_a ();
    arbitro_rr_4_if if_b ();

    arbitro_rr_4 #(.TIEMPO_MAX(8), .ANCHO_CNT(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    arbitro_rr_4 #(.TIEMPO_MAX(1), .ANCHO_CNT(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        if_a.sol     = 4'b0000;
        if_a.liberar = 1'b0;
        if_b.sol     = 4'b0000;
        if_b.liberar = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        if_a.sol     = 4'b1111;
        if_a.liberar = 1'b0;
        if_b.sol     = 4'b0000;
        if_b.liberar = 1'b0;
        step();
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: got en,idx=%b want 000",
                     {if_a.en, if_a.a1, if_a.a0});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b100) begin
            errors++;
            $display("FAIL reset_first_grant: got en,idx=%b want 100",
                     {if_a.en, if_a.a1, if_a.a0});
        end
    endtask

    task automatic test_single();
        do_reset();
        if_a.sol = 4'b0010;
        for (int c = 0; c < 18; c++) begin
            step();
            checks++;
            if ({if_a.en, if_a.a1, if_a.a0} !== 3'b101) begin
                errors++;
                $display("FAIL single_hold c=%0d: got en,idx=%b want 101",
                         c, {if_a.en, if_a.a1, if_a.a0});
            end
        end
        if_a.sol = 4'b0000;
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b001) begin
            errors++;
            $display("FAIL single_drop: got en,idx=%b want 001",
                     {if_a.en, if_a.a1, if_a.a0});
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_idx;
        logic [3:0] y;
        logic [3:0] exp_y;
        do_reset();
        if_a.sol = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            step();
            exp_idx = 2'((c / 8) % 4);
            exp_y   = 4'b0001 << exp_idx;
            y       = if_a.en ? (4'b0001 << {if_a.a1, if_a.a0}) : 4'b0000;
            checks++;
            if ({if_a.en, if_a.a1, if_a.a0} !== {1'b1, exp_idx}) begin
                errors++;
                $display("FAIL rotation_idx c=%0d: got en,idx=%b want 1%b",
                         c, {if_a.en, if_a.a1, if_a.a0}, exp_idx);
            end
            checks++;
            if (y !== exp_y) begin
                errors++;
                $display("FAIL rotation_y c=%0d: got %b want %b",
                         c, y, exp_y);
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        if_a.sol = 4'b0101;
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b100) begin
            errors++;
            $display("FAIL release_first: got en,idx=%b want 100",
                     {if_a.en, if_a.a1, if_a.a0});
        end
        if_a.liberar = 1'b1;
        step();
        if_a.liberar = 1'b0;
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b110) begin
            errors++;
            $display("FAIL release_pulse: got en,idx=%b want 110",
                     {if_a.en, if_a.a1, if_a.a0});
        end
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b110) begin
            errors++;
            $display("FAIL release_hold2: got en,idx=%b want 110",
                     {if_a.en, if_a.a1, if_a.a0});
        end
        if_a.sol = 4'b0001;
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b100) begin
            errors++;
            $display("FAIL release_drop: got en,idx=%b want 100",
                     {if_a.en, if_a.a1, if_a.a0});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        if_a.sol = 4'b1000;
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b111) begin
            errors++;
            $display("FAIL midrst_grant3: got en,idx=%b want 111",
                     {if_a.en, if_a.a1, if_a.a0});
        end
        rst_n        = 1'b0;
        if_a.sol     = 4'b1111;
        if_a.liberar = 1'b1;
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_off: got en,idx=%b want 000",
                     {if_a.en, if_a.a1, if_a.a0});
        end
        rst_n        = 1'b1;
        if_a.liberar = 1'b0;
        step();
        checks++;
        if ({if_a.en, if_a.a1, if_a.a0} !== 3'b100) begin
            errors++;
            $display("FAIL midrst_resume: got en,idx=%b want 100",
                     {if_a.en, if_a.a1, if_a.a0});
        end
    endtask

    task automatic test_tmax1();
        logic [1:0] exp_idx;
        do_reset();
        if_b.sol = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            step();
            exp_idx = (c % 2 == 0) ? 2'd0 : 2'd3;
            checks++;
            if ({if_b.en, if_b.a1, if_b.a0} !== {1'b1, exp_idx}) begin
                errors++;
                $display("FAIL tmax1_alt c=%0d: got en,idx=%b want 1%b",
                         c, {if_b.en, if_b.a1, if_b.a0}, exp_idx);
            end
        end
        if_b.sol = 4'b0000;
        step();
        checks++;
        if (if_b.en !== 1'b0) begin
            errors++;
            $display("FAIL tmax1_idle: got en=%b want 0", if_b.en);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_rotation();
        test_early_release();
        test_mid_reset();
        test_tmax1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/arbitro_rr_4.md
# arbitro_rr_4

- Four-requester round-robin arbiter with a bounded tenure.
- Sits directly upstream of the 2-to-4 decoder:
  - it drives the decoder's `a0`, `a1` and `en` inputs;
  - the decoder's `y0..y3` therefore form the one-hot grant bus.
- When enabled, the grant is always exactly one requester; when idle, `en` is 0, so every `y` is 0.
- All outputs are registered. Arbitration is fair: each new grant starts the search just after the last granted index.

## Interface
Parameters:
- `TIEMPO_MAX`, 8, maximum consecutive cycles one requester may hold the grant. Legal range is 1..2^ANCHO_CNT−1.
- `ANCHO_CNT`, 4, width of the tenure counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `sol`  in  4  request vector; `sol[i]`=1 means requester i wants the grant. Sampled every edge.
- `liberar`  in  1  explicit release of the current grant. Ignored when idle.
- `a0`  out  1  granted index, bit 0 (to decoder `a0`).
- `a1`  out  1  granted index, bit 1 (to decoder `a1`).
- `en`  out  1  grant valid (to decoder `en`).

## Operation
- Reset (`rst_n`=0 at an edge):
  - state `REPOSO`;
  - `en`=0, `a1`=0, `a0`=0;
  - pointer `ptr`=0;
  - tenure counter `cnt`=0.
- Pick function `elegir(v, ptr)`: the first index i in the order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4) with `v[i]`=1.
- `REPOSO`:
  - if `sol`≠0, load {`a1`,`a0`} ← `elegir(sol, ptr)`, set `en`←1, `cnt`←0, `ptr`← index+1 (mod 4), and go to `CONCEDIDO`;
  - otherwise hold, with `en`=0 and `a1`/`a0` unchanged.
- `CONCEDIDO`, current index g = {`a1`,`a0`}. The tenure ends at an edge when any of these holds:
  - `sol[g]`=0;
  - `liberar`=1;
  - `cnt`=TIEMPO_MAX−1.
- `CONCEDIDO`, no end condition: stay in state and set `cnt`←`cnt`+1. `cnt` never wraps, because it is bounded by TIEMPO_MAX−1.
- `CONCEDIDO`, end condition at an edge:
  - if `sol`≠0, regrant immediately (zero bubble) with `elegir(sol, ptr)`, `cnt`←0, `ptr` updated as in `REPOSO`; `en` stays 1;
  - if `sol`=0, set `en`←0, go to `REPOSO`, and keep `a1`/`a0` at their last value.
- Requester g is still eligible at the end of its own tenure. It has the lowest priority, because `ptr` already points past it. A sole requester therefore gets regranted with `cnt` restarted.
- `TIEMPO_MAX`=1: every granted cycle is an end condition, so arbitration happens every cycle.
- Unused encodings of the state register go to `REPOSO` with `en`=0.

## Timing
- Grant latency is 1 cycle. `sol` is sampled at edge k, and `en`/`a1`/`a0` are valid after edge k.
- Release latency is 1 cycle. A dropped `sol[g]` or a `liberar` pulse sampled at edge k changes the outputs after edge k.
- Maximum tenure is TIEMPO_MAX consecutive cycles with the same g.
- Worst-case wait for a continuously requesting input is 3·TIEMPO_MAX cycles.
- Simultaneous events:
  - `liberar`=1 together with `sol[g]`=0 is a single end event;
  - `liberar` at timeout is also a single end event;
  - a new request arriving in the same cycle as an end is considered in that edge's pick.
- Reset mid-grant: `en`=0 after the reset edge, regardless of `sol` or `liberar`. Arbitration resumes from index 0.
- `a1`/`a0` change only on a grant, and only while `en` is about to be 1. The decoder therefore never sees an index change under `en`=1 except on a legitimate regrant edge.

## Test plan
- Reset: hold `rst_n`=0 with `sol`=4'b1111. Required: `en`=0, {`a1`,`a0`}=00. After the first edge with `rst_n`=1: `en`=1, {`a1`,`a0`}=00.
- Single requester, `sol`=4'b0010 held, TIEMPO_MAX=8:
  - one edge later, {`a1`,`a0`}=01 and `en`=1;
  - after 8 cycles, a regrant to 01 with `en` never dropping;
  - `sol`→0: `en`=0 after the next edge.
- Rotation, `sol`=4'b1111 held, TIEMPO_MAX=8:
  - the granted index sequence is 0,1,2,3,0, each held exactly 8 cycles;
  - decoder `y` shows 0001, 0010, 0100, 1000.
- Early release:
  - `sol`=4'b0101, 1-cycle `liberar` pulse during the grant to 0: next grant is 2 on the following edge;
  - drop `sol[2]` while granted with `sol`=4'b0001: grant returns to 0.
- Mid-grant reset and `TIEMPO_MAX`=1:
  - `rst_n`=0 during the grant to 3: `en`=0 on the next edge;
  - with `TIEMPO_MAX`=1 and `sol`=4'b1001: grants alternate 0,3,0,3 every cycle.
